// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle between a pipeline stage register and its neighbours.
// master: the environment (upstream producer plus downstream consumer).
// slave: the stage register itself.
interface pipe_stage_reg_if #(
    parameter int unsigned WIDTH = 32
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

endinterface

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with a valid/ready handshake, an optional
// one-entry skid buffer, a global stall hold and a synchronous flush.
// The main entry drives the outputs; the skid entry only catches the payload
// that arrives in the cycle downstream backpressure is first seen.
module pipe_stage_reg #(
    parameter int unsigned      WIDTH  = 32,
    parameter logic [WIDTH-1:0] BUBBLE = '0,
    parameter bit               SKID   = 1'b1
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              stall,
    input  logic              flush,
    output logic [1:0]        occupancy,
    pipe_stage_reg_if.slave   bus
);

    // State encoding equals the number of entries held.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] main_q,  main_d;
    logic [WIDTH-1:0] skid_q,  skid_d;

    logic hold;
    logic room;
    logic push;
    logic pop;

    assign hold = stall | flush;

    // Space available: with a skid entry this looks only at registered state,
    // without one it relies on downstream draining the main entry this cycle.
    always_comb begin
        room = 1'b0;
        if (SKID) begin
            room = (state_q != StFull);
        end else begin
            room = (state_q == StEmpty) | bus.out_ready;
        end
    end

    assign bus.in_ready = ~hold & room;
    assign push         = bus.in_valid & bus.in_ready;
    assign pop          = valid_q & bus.out_ready & ~hold;

    // Next-state logic; flush dominates stall, stall freezes everything.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = StEmpty;
            valid_d = 1'b0;
            main_d  = BUBBLE;
            skid_d  = BUBBLE;
        end else if (!stall) begin
            case (state_q)
                StEmpty: begin
                    if (push) begin
                        state_d = StOne;
                        valid_d = 1'b1;
                        main_d  = bus.in_data;
                    end
                end
                StOne: begin
                    if (push && pop) begin
                        main_d = bus.in_data;
                    end else if (push && SKID) begin
                        // Downstream stalled: park the new payload behind main.
                        state_d = StFull;
                        skid_d  = bus.in_data;
                    end else if (pop) begin
                        state_d = StEmpty;
                        valid_d = 1'b0;
                        main_d  = BUBBLE;
                    end
                end
                StFull: begin
                    // in_ready is low here, so only a drain can happen.
                    if (pop) begin
                        state_d = StOne;
                        main_d  = skid_q;
                        skid_d  = BUBBLE;
                    end
                end
                default: begin
                    state_d = StEmpty;
                    valid_d = 1'b0;
                    main_d  = BUBBLE;
                    skid_d  = BUBBLE;
                end
            endcase
        end
    end

    // State and payload registers, cleared to the bubble on reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= StEmpty;
            valid_q <= 1'b0;
            main_q  <= BUBBLE;
            skid_q  <= BUBBLE;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_data  = main_q;
    assign occupancy     = state_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: one instance with the skid entry and
// one single-entry instance with a non-zero bubble encoding.
module tb_pipe_stage_reg;

    localparam logic [31:0] NopBubble = 32'h0000_0013;

    logic       CLK;
    logic       nRST;
    logic       s_stall, s_flush, n_stall, n_flush;
    logic [1:0] s_occ, n_occ;

    int n_checks = 0;
    int n_errors = 0;

    pipe_stage_reg_if #(.WIDTH(32)) s_if ();
    pipe_stage_reg_if #(.WIDTH(32)) n_if ();

    pipe_stage_reg #(
        .WIDTH  (32),
        .BUBBLE (32'h0),
        .SKID   (1'b1)
    ) u_skid (
        .CLK       (CLK),
        .nRST      (nRST),
        .stall     (s_stall),
        .flush     (s_flush),
        .occupancy (s_occ),
        .bus       (s_if.slave)
    );

    pipe_stage_reg #(
        .WIDTH  (32),
        .BUBBLE (NopBubble),
        .SKID   (1'b0)
    ) u_noskid (
        .CLK       (CLK),
        .nRST      (nRST),
        .stall     (n_stall),
        .flush     (n_flush),
        .occupancy (n_occ),
        .bus       (n_if.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        nRST            = 1'b0;
        s_stall         = 1'b0;
        s_flush         = 1'b0;
        n_stall         = 1'b0;
        n_flush         = 1'b0;
        s_if.in_valid   = 1'b1;
        s_if.in_data    = 32'hDEAD_BEEF;
        s_if.out_ready  = 1'b0;
        n_if.in_valid   = 1'b0;
        n_if.in_data    = 32'h0;
        n_if.out_ready  = 1'b0;

        // Reset held across edges with a valid input present.
        #12;
        chk("rst_valid", {31'b0, s_if.out_valid}, 32'd0);
        chk("rst_data", s_if.out_data, 32'h0);
        chk("rst_occ", {30'b0, s_occ}, 32'd0);
        chk("rst_nbubble", n_if.out_data, NopBubble);
        s_if.in_valid = 1'b0;
        nRST          = 1'b1;
        #1;
        chk("rel_ready", {31'b0, s_if.in_ready}, 32'd1);
        chk("rel_nready", {31'b0, n_if.in_ready}, 32'd1);

        // Streaming at one payload per cycle.
        s_if.out_ready = 1'b1;
        s_if.in_valid  = 1'b1;
        s_if.in_data   = 32'h1;
        tick();
        chk("str_d1", s_if.out_data, 32'h1);
        chk("str_o1", {30'b0, s_occ}, 32'd1);
        s_if.in_data = 32'h2;
        tick();
        chk("str_d2", s_if.out_data, 32'h2);
        chk("str_o2", {30'b0, s_occ}, 32'd1);
        s_if.in_data = 32'h3;
        tick();
        chk("str_d3", s_if.out_data, 32'h3);
        chk("str_v3", {31'b0, s_if.out_valid}, 32'd1);
        s_if.in_valid = 1'b0;
        tick();
        chk("str_empty", {30'b0, s_occ}, 32'd0);
        chk("str_bubble", s_if.out_data, 32'h0);

        // Backpressure fills the skid entry; drain keeps FIFO order.
        s_if.out_ready = 1'b0;
        s_if.in_valid  = 1'b1;
        s_if.in_data   = 32'hA;
        tick();
        chk("bp_occ1", {30'b0, s_occ}, 32'd1);
        chk("bp_ready1", {31'b0, s_if.in_ready}, 32'd1);
        s_if.in_data = 32'hB;
        tick();
        chk("bp_occ2", {30'b0, s_occ}, 32'd2);
        chk("bp_ready2", {31'b0, s_if.in_ready}, 32'd0);
        chk("bp_headA", s_if.out_data, 32'hA);
        s_if.in_valid  = 1'b0;
        s_if.out_ready = 1'b1;
        tick();
        chk("bp_nextB", s_if.out_data, 32'hB);
        chk("bp_occ_after", {30'b0, s_occ}, 32'd1);
        tick();
        chk("bp_drained", {30'b0, s_occ}, 32'd0);
        chk("bp_bubble", s_if.out_data, 32'h0);
        chk("bp_valid0", {31'b0, s_if.out_valid}, 32'd0);

        // Stall freezes a held payload even with both sides ready.
        s_if.out_ready = 1'b0;
        s_if.in_valid  = 1'b1;
        s_if.in_data   = 32'h55;
        tick();
        s_stall        = 1'b1;
        s_if.in_data   = 32'h66;
        s_if.out_ready = 1'b1;
        #1;
        chk("stl_ready_comb", {31'b0, s_if.in_ready}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stl_data", s_if.out_data, 32'h55);
            chk("stl_occ", {30'b0, s_occ}, 32'd1);
        end
        s_stall       = 1'b0;
        s_if.in_valid = 1'b0;
        tick();
        chk("stl_consumed", {30'b0, s_occ}, 32'd0);
        chk("stl_valid0", {31'b0, s_if.out_valid}, 32'd0);

        // Flush together with stall empties a full stage and drops input.
        s_if.out_ready = 1'b0;
        s_if.in_valid  = 1'b1;
        s_if.in_data   = 32'hE1;
        tick();
        s_if.in_data = 32'hE2;
        tick();
        chk("fl_full", {30'b0, s_occ}, 32'd2);
        s_flush      = 1'b1;
        s_stall      = 1'b1;
        s_if.in_data = 32'h77;
        #1;
        chk("fl_ready_comb", {31'b0, s_if.in_ready}, 32'd0);
        tick();
        chk("fl_occ", {30'b0, s_occ}, 32'd0);
        chk("fl_valid", {31'b0, s_if.out_valid}, 32'd0);
        chk("fl_bubble", s_if.out_data, 32'h0);
        s_flush        = 1'b0;
        s_stall        = 1'b0;
        s_if.in_valid  = 1'b0;
        s_if.out_ready = 1'b1;
        tick();
        chk("fl_no77_valid", {31'b0, s_if.out_valid}, 32'd0);
        chk("fl_no77_data", s_if.out_data, 32'h0);

        // Single-entry stage: combinational in_ready from out_ready.
        n_if.out_ready = 1'b0;
        n_if.in_valid  = 1'b1;
        n_if.in_data   = 32'hC;
        #1;
        chk("ns_ready_empty", {31'b0, n_if.in_ready}, 32'd1);
        tick();
        chk("ns_occ1", {30'b0, n_occ}, 32'd1);
        chk("ns_dataC", n_if.out_data, 32'hC);
        chk("ns_ready_blk", {31'b0, n_if.in_ready}, 32'd0);
        n_if.out_ready = 1'b1;
        n_if.in_data   = 32'hD;
        #1;
        chk("ns_ready_comb", {31'b0, n_if.in_ready}, 32'd1);
        tick();
        chk("ns_dataD", n_if.out_data, 32'hD);
        chk("ns_occD", {30'b0, n_occ}, 32'd1);
        n_if.in_valid = 1'b0;
        tick();
        chk("ns_empty", {30'b0, n_occ}, 32'd0);
        chk("ns_bubble", n_if.out_data, NopBubble);

        // Asynchronous reset mid-operation discards the held entry.
        s_if.out_ready = 1'b0;
        s_if.in_valid  = 1'b1;
        s_if.in_data   = 32'h99;
        tick();
        s_if.in_valid = 1'b0;
        chk("ar_occ1", {30'b0, s_occ}, 32'd1);
        #1;
        nRST = 1'b0;
        #1;
        chk("ar_occ0", {30'b0, s_occ}, 32'd0);
        chk("ar_data", s_if.out_data, 32'h0);
        #2;
        nRST = 1'b1;
        tick();
        chk("ar_after_occ", {30'b0, s_occ}, 32'd0);
        chk("ar_after_ready", {31'b0, s_if.in_ready}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register that replaces the hand-written per-field inter-stage latches with one generic, width-configurable stage carrying a packed payload. Adds a valid/ready handshake, an optional one-entry skid buffer for full throughput under backpressure, a global stall hold and a synchronous flush that inserts a bubble. It sits between any two CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). Control fields are packed into the payload by the instantiating stage.

## Interface
Parameters:
- WIDTH, 32: payload width in bits (≥1).
- BUBBLE, '0: WIDTH-bit payload value driven whenever the stage is empty (NOP encoding).
- SKID, 1: 1 = two-entry stage (main + skid) with registered-only in_ready; 0 = single entry with combinational in_ready.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- stall  in  1  global hold; freezes all state and blocks both transfers.
- flush  in  1  synchronous flush; empties the stage; priority over stall and transfers.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  main entry holds a valid payload.
- out_ready  in  1  downstream accepts.
- out_data  out  WIDTH  main entry payload (BUBBLE when empty).
- occupancy  out  2  entries held: 0, 1, or 2 (2 only when SKID=1).

## Operation
- Transfer definitions: i = in_valid & in_ready; o = out_valid & out_ready & !stall & !flush.
- in_ready = !stall & !flush & (SKID ? occupancy!=2 : (occupancy==0 | out_ready)).
  - SKID=1: in_ready depends only on registered state plus stall/flush.
  - SKID=0: in_ready has a combinational path from out_ready.
- States follow occupancy:
  - EMPTY (0): out_valid=0, out_data=BUBBLE.
  - ONE (1): main entry valid.
  - FULL (2): main and skid entries valid.
- Transitions when flush=0 and stall=0:
  - EMPTY: i → ONE, main←in_data.
  - ONE: i&!o → FULL, skid←in_data (SKID=1 only). i&o → ONE, main←in_data. !i&o → EMPTY, main←BUBBLE.
  - FULL: i is impossible. o → ONE, main←skid, skid←BUBBLE.
- stall=1 and flush=0: every register holds its value; in_ready=0; no transfer.
- flush=1, regardless of stall: next state EMPTY, main/skid←BUBBLE, occupancy←0. A concurrent in_valid is dropped (in_ready=0 that cycle).
- Ordering: strict FIFO. The skid entry always leaves after the main entry. No payload is duplicated or lost except by flush.
- Payload is stored verbatim; no arithmetic on data.

## Timing
- Reset (nRST=0, async) sets: out_valid=0, out_data=BUBBLE, occupancy=0, skid=BUBBLE. in_ready=1 immediately whenever stall=flush=0.
- Latency: in_data accepted at edge N appears on out_data after edge N (1 cycle).
- Throughput: 1 payload/cycle with out_ready held high.
  - SKID=1 sustains full throughput across a single-cycle out_ready deassertion.
  - SKID=0 drops to a bubble per backpressure cycle.
- out_valid, out_data and occupancy are registered outputs (glitch-free).
- Reset asserted mid-operation discards all entries. The first cycle after release behaves as EMPTY.
- flush and stall asserted together: flush wins and the stage is empty at the next edge.

## Test plan
- Reset: hold nRST=0 with in_valid=1 and in_data=0xDEADBEEF → out_valid=0, out_data=0, occupancy=0. After release with stall=0, in_ready=1.
- Streaming: SKID=1, out_ready=1, push 0x1,0x2,0x3 on consecutive cycles → out_data shows 0x1,0x2,0x3 one cycle after each push, occupancy=1 throughout, no bubbles.
- Backpressure and skid: SKID=1, push 0xA then 0xB with out_ready=0 → occupancy=2, in_ready=0, out_data=0xA. Raise out_ready → 0xA then 0xB emitted in order, then occupancy=0 and out_data=BUBBLE.
- Stall hold: occupancy=1 with out_data=0x55, stall=1 for 3 cycles with in_valid=1 and out_ready=1 → out_data stays 0x55, in_ready=0, occupancy=1. On release, 0x55 is consumed.
- Flush priority: occupancy=2 with flush=1, stall=1 and in_valid=1 (data 0x77) → next cycle occupancy=0, out_valid=0, out_data=BUBBLE. 0x77 never appears.
- SKID=0: out_ready=0, push 0xC → occupancy=1, in_ready=0. Set out_ready=1 with in_valid=1 (0xD) → same-cycle in_ready=1, next out_data=0xD.
